// File: rtl/alarme_ctrl.sv
// Alarm controller: turns button presses into set-mode controls for the digit setter,
// and runs the armed/ring/snooze sequence off a registered time-match edge.
module alarme_ctrl #(
  parameter int unsigned INC_PULSE_CYC = 4,
  parameter int unsigned RING_TIMEOUT  = 60,
  parameter int unsigned SNOOZE_SEC    = 120,
  parameter int unsigned MAX_SNOOZE    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_modo,
  input  logic        btn_sel,
  input  logic        btn_inc,
  input  logic        btn_arm,
  input  logic        btn_stop,
  input  logic        tick_1hz,
  input  logic [23:0] hora_atual,
  input  logic [23:0] alarme_completo,
  output logic [2:0]  seletor,
  output logic        alarme_ativo,
  output logic        incremento,
  output logic        armado,
  output logic        tocando,
  output logic        buzzer,
  output logic [1:0]  snooze_cnt
);

  localparam int unsigned TMax = (RING_TIMEOUT > SNOOZE_SEC) ? RING_TIMEOUT : SNOOZE_SEC;
  localparam int unsigned TW   = $clog2(TMax + 1);
  localparam int unsigned IW   = $clog2(INC_PULSE_CYC + 1);

  localparam logic [TW-1:0] RingLast  = TW'(RING_TIMEOUT - 1);
  localparam logic [TW-1:0] SnoozeLd  = TW'(SNOOZE_SEC);
  localparam logic [IW-1:0] IncLd     = IW'(INC_PULSE_CYC);
  localparam logic [1:0]    MaxSnooze = 2'(MAX_SNOOZE);

  typedef enum logic [2:0] {StIdle, StSet, StArmed, StRing, StSnooze} state_t;

  state_t        state_q, state_d;
  logic [4:0]    btn_now, btn_lvl_q, btn_prev_q, btn_edge;
  logic          ev_stop, ev_arm, ev_modo, ev_sel, ev_inc;
  logic          match, match_q, match_rise;
  logic [2:0]    sel_q, sel_d;
  logic [IW-1:0] inc_q, inc_d;
  logic          pend_q, pend_d, pend_arm_q, pend_arm_d;
  logic [TW-1:0] ring_q, ring_d, snz_q, snz_d;
  logic          blink_q, blink_d;
  logic [1:0]    scnt_q, scnt_d;

  // Bit order doubles as priority, lowest to highest: inc, sel, modo, arm, stop.
  assign btn_now  = {btn_stop, btn_arm, btn_modo, btn_sel, btn_inc};
  assign btn_edge = btn_lvl_q & ~btn_prev_q;

  assign ev_stop = btn_edge[4];
  assign ev_arm  = btn_edge[3] & ~btn_edge[4];
  assign ev_modo = btn_edge[2] & ~(|btn_edge[4:3]);
  assign ev_sel  = btn_edge[1] & ~(|btn_edge[4:2]);
  assign ev_inc  = btn_edge[0] & ~(|btn_edge[4:1]);

  assign match      = (hora_atual == alarme_completo);
  assign match_rise = match & ~match_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      btn_lvl_q  <= btn_now;
      btn_prev_q <= btn_now;
      match_q    <= match;
      sel_q      <= 3'd0;
      inc_q      <= '0;
      pend_q     <= 1'b0;
      pend_arm_q <= 1'b0;
      ring_q     <= '0;
      snz_q      <= '0;
      blink_q    <= 1'b0;
      scnt_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      btn_lvl_q  <= btn_now;
      btn_prev_q <= btn_lvl_q;
      match_q    <= match;
      sel_q      <= sel_d;
      inc_q      <= inc_d;
      pend_q     <= pend_d;
      pend_arm_q <= pend_arm_d;
      ring_q     <= ring_d;
      snz_q      <= snz_d;
      blink_q    <= blink_d;
      scnt_q     <= scnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    inc_d      = (inc_q != '0) ? inc_q - IW'(1) : inc_q;
    pend_d     = pend_q;
    pend_arm_d = pend_arm_q;
    ring_d     = ring_q;
    snz_d      = snz_q;
    blink_d    = blink_q;
    scnt_d     = scnt_q;

    unique case (state_q)
      StIdle: begin
        if (ev_arm) begin
          state_d = StArmed;
        end else if (ev_modo) begin
          state_d = StSet;
          sel_d   = 3'd0;
        end
      end
      StSet: begin
        // A requested exit is held until the running increment pulse has finished.
        if (pend_q) begin
          if (inc_q == '0) begin
            state_d = pend_arm_q ? StArmed : StIdle;
            sel_d   = 3'd0;
            pend_d  = 1'b0;
          end
        end else if (ev_arm || ev_modo) begin
          if (inc_q == '0) begin
            state_d = ev_modo ? StArmed : StIdle;
            sel_d   = 3'd0;
          end else begin
            pend_d     = 1'b1;
            pend_arm_d = ev_modo;
          end
        end else if (ev_sel) begin
          sel_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
        end else if (ev_inc && inc_q == '0) begin
          inc_d = IncLd;
        end
      end
      StArmed: begin
        if (ev_arm) begin
          state_d = StIdle;
        end else if (ev_modo) begin
          state_d = StSet;
          sel_d   = 3'd0;
        end else if (match_rise) begin
          state_d = StRing;
          ring_d  = '0;
          blink_d = 1'b0;
          scnt_d  = 2'd0;
        end
      end
      StRing: begin
        if (ev_stop) begin
          state_d = StArmed;
        end else if (ev_arm) begin
          state_d = StIdle;
        end else if (ev_sel) begin
          if (scnt_q < MaxSnooze) begin
            state_d = StSnooze;
            scnt_d  = scnt_q + 2'd1;
            snz_d   = SnoozeLd;
          end else begin
            state_d = StArmed;
          end
        end else if (tick_1hz) begin
          blink_d = ~blink_q;
          if (ring_q >= RingLast) begin
            state_d = StArmed;
          end else begin
            ring_d = ring_q + TW'(1);
          end
        end
      end
      StSnooze: begin
        if (ev_stop) begin
          state_d = StArmed;
        end else if (ev_arm) begin
          state_d = StIdle;
        end else if (tick_1hz) begin
          if (snz_q <= TW'(1)) begin
            state_d = StRing;
            snz_d   = '0;
            ring_d  = '0;
            blink_d = 1'b0;
          end else begin
            snz_d = snz_q - TW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StArmed || state_d == StIdle) scnt_d = 2'd0;
  end

  assign seletor      = sel_q;
  assign alarme_ativo = (state_q == StSet);
  assign incremento   = (inc_q != '0);
  assign armado       = (state_q == StArmed) || (state_q == StRing) || (state_q == StSnooze);
  assign tocando      = (state_q == StRing);
  assign buzzer       = tocando & blink_q;
  assign snooze_cnt   = scnt_q;

endmodule

// File: doc/alarme_ctrl.md
Name: alarme_ctrl

Overview:
- Controller that sequences the alarm-setting digit counters and decides when the alarm rings.
- Converts four push-button levels into digit select (seletor), a set-mode enable (alarme_ativo) and timed increment pulses for the setter.
- Compares the stored alarm time (alarme_completo) with the running clock (hora_atual) and drives a ring/snooze state machine with timeout.
- Sits between the button inputs, the alarm setter and the time-keeping block.

Parameters:
- INC_PULSE_CYC, 4: cycles incremento is held high per btn_inc press (≥2 so the setter samples it).
- RING_TIMEOUT, 60: seconds (tick_1hz pulses) of ringing before auto-stop.
- SNOOZE_SEC, 120: seconds spent in SNOOZE before re-ringing.
- MAX_SNOOZE, 3: number of snoozes allowed per alarm event.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- btn_modo, input, 1: enter/exit set mode; level, already synchronized.
- btn_sel, input, 1: next digit in SET; snooze in RING.
- btn_inc, input, 1: increment the selected digit.
- btn_arm, input, 1: toggle armed/disarmed.
- btn_stop, input, 1: stop ringing.
- tick_1hz, input, 1: one-cycle pulse per second.
- hora_atual, input, 24: current time, BCD {hh,mm,ss}, 4 bits per digit.
- alarme_completo, input, 24: alarm time from the setter, same format.
- seletor, output, 3: digit select 0..5 (0 = seconds units … 5 = hours tens).
- alarme_ativo, output, 1: set-mode enable to the setter.
- incremento, output, 1: increment pulse to the setter.
- armado, output, 1: high in ARMED, RING, SNOOZE.
- tocando, output, 1: high in RING.
- buzzer, output, 1: tocando AND a 1 Hz blink bit; the blink bit toggles on each tick_1hz while in RING and is cleared on entry to RING.
- snooze_cnt, output, 2: snoozes used in the current alarm event.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE; all outputs 0.
  - Internal counters cleared; button edge registers loaded with the current button levels, so a held button does not fire after reset.
- Buttons: internal rising-edge detect, one event per press. If several events arrive in the same cycle, only the highest-priority one acts: btn_stop > btn_arm > btn_modo > btn_sel > btn_inc.
- Match detect:
  - match = (hora_atual == alarme_completo); match_q is registered every cycle.
  - match_rise = match & ~match_q. Only match_rise triggers a ring, so a frozen clock cannot retrigger.
- States (state encoding is free):
  - IDLE: btn_modo -> SET; btn_arm -> ARMED.
  - SET:
    - alarme_ativo=1; seletor=0 on entry.
    - btn_sel: seletor +1, wraps 5 -> 0.
    - btn_inc: incremento=1 for exactly INC_PULSE_CYC cycles starting the cycle after the edge. Further btn_inc edges during an active pulse are ignored.
    - btn_modo -> ARMED. The transition waits until any active increment pulse ends; seletor and alarme_ativo then go to 0.
    - btn_arm -> IDLE under the same wait rule.
    - No match detection in SET.
  - ARMED:
    - match_rise -> RING, with ring_timer=0, blink=0, snooze_cnt=0.
    - btn_arm -> IDLE; btn_modo -> SET.
  - RING:
    - ring_timer +1 per tick_1hz; when it reaches RING_TIMEOUT -> ARMED.
    - btn_stop -> ARMED.
    - btn_arm -> IDLE.
    - btn_sel: if snooze_cnt < MAX_SNOOZE -> SNOOZE, snooze_cnt +1, snooze_timer=SNOOZE_SEC; otherwise it acts as btn_stop.
  - SNOOZE:
    - tocando=0.
    - snooze_timer -1 per tick_1hz; on reaching 0 -> RING, with ring_timer=0 and blink=0; snooze_cnt is kept.
    - btn_stop -> ARMED, snooze_cnt=0.
    - btn_arm -> IDLE.
- snooze_cnt clears on every entry to ARMED or IDLE.
- Timing: all state changes take effect on the clk edge after the button edge is detected, i.e. 2 cycles after the button input rises.
- Widths:
  - ring_timer and snooze_timer are $clog2(max(RING_TIMEOUT, SNOOZE_SEC)+1) bits and never wrap.
  - A tick_1hz in the same cycle as a state-changing button is ignored.
- Reset mid-ring or mid-pulse: incremento drops the next cycle and state returns to IDLE.

Test Plan:
- Reset with all buttons held high, release reset -> outputs all 0, state IDLE, no events fire until the buttons are released and pressed again.
- SET navigation: btn_modo, then btn_sel pressed 7 times -> seletor sequence 1,2,3,4,5,0,1. One btn_inc -> incremento high for exactly 4 cycles. A second btn_inc inside the pulse -> no extension.
- Arm and match: btn_arm; hora_atual steps 06:59:59 -> 07:00:00 with alarme_completo=24'h070000 -> tocando=1 one cycle after the change. hora_atual held equal -> no retrigger after btn_stop.
- Timeout: ring, apply 60 tick_1hz pulses -> tocando falls and state is ARMED; buzzer toggles every tick while ringing.
- Snooze: ring, btn_sel -> SNOOZE, snooze_cnt=1; 120 ticks -> RING again. Repeat to snooze_cnt=3, then a fourth btn_sel -> ARMED, snooze_cnt=0.
- Priority and mid-operation reset: btn_stop and btn_sel in the same cycle during RING -> ARMED, not SNOOZE. reset_n=0 during RING -> IDLE and all outputs 0 at the next edge.
